// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-control types: PC-source codes,
// sequencer states and redirect priority.
package fetch_sequencer_pkg;

  localparam int SEL_CODE_W = 4;

  typedef logic [SEL_CODE_W-1:0] sel_t;

  localparam sel_t SEL_INIT   = 4'd0;
  localparam sel_t SEL_NEXT   = 4'd1;
  localparam sel_t SEL_BRANCH = 4'd2;
  localparam sel_t SEL_JUMP   = 4'd3;
  localparam sel_t SEL_EXC    = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOOT,
    ST_RUN,
    ST_MEM_WAIT,
    ST_ERROR
  } fetch_state_t;

  // Highest-priority redirect as its PC-source code.
  // SEL_INIT means no redirect. Codes rise with
  // priority, so a plain compare orders them.
  function automatic sel_t redirect_code(
    input logic exc,
    input logic jmp,
    input logic br
  );
    sel_t code;
    priority case (1'b1)
      exc:     code = SEL_EXC;
      jmp:     code = SEL_JUMP;
      br:      code = SEL_BRANCH;
      default: code = SEL_INIT;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch control bus between decode/execute control,
// instruction memory status and the fetch datapath.
interface fetch_sequencer_if #(
  parameter int SEL_W = 4
);
  logic             start;
  logic             stall;
  logic             branch_taken;
  logic             jump;
  logic             exception;
  logic             mem_ready;
  logic [SEL_W-1:0] sel;
  logic             enable;
  logic             mem_req;
  logic             fetch_valid;
  logic             mem_error;
  logic             busy;

  modport master (
    output start, stall, branch_taken,
    output jump, exception, mem_ready,
    input  sel, enable, mem_req,
    input  fetch_valid, mem_error, busy
  );

  modport slave (
    input  start, stall, branch_taken,
    input  jump, exception, mem_ready,
    output sel, enable, mem_req,
    output fetch_valid, mem_error, busy
  );
endinterface

// File: rtl/fetch_wait_timer.sv
// Counts consecutive instruction-memory wait cycles
// and flags when the count reaches MEM_TIMEOUT.
module fetch_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_inc,
  output logic o_expired
);
  logic [7:0] r_count;

  // Clear, load first wait cycle, or saturating step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= 8'd1;
    end else if (i_inc && r_count != 8'hFF) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count == 8'(MEM_TIMEOUT));
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control: PC-source select and PC load
// enable across boot, redirects, stalls and waits.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int SEL_W       = 4
) (
  input logic         clk,
  input logic         reset,
  fetch_sequencer_if.slave bus
);
  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  sel_t         r_pend;
  sel_t         w_pend_nxt;
  logic         r_mem_error;
  logic         w_err_set;

  sel_t w_redir;
  sel_t w_eff;
  sel_t w_sel;
  logic w_en;
  logic w_req;
  logic w_fv;
  logic w_t_clr;
  logic w_t_load;
  logic w_t_inc;
  logic w_expired;

  fetch_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_t_clr),
    .i_load   (w_t_load),
    .i_inc    (w_t_inc),
    .o_expired(w_expired)
  );

  assign w_redir = redirect_code(
    bus.exception, bus.jump, bus.branch_taken);

  // A stored redirect yields only to a stronger one
  assign w_eff = (r_pend > w_redir) ? r_pend
                                    : w_redir;

  // State, pending redirect and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pend      <= SEL_INIT;
      r_mem_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (w_err_set) begin
        r_mem_error <= 1'b1;
      end
    end
  end

  // Next state and zero-latency PC controls
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_err_set   = 1'b0;
    w_sel       = SEL_INIT;
    w_en        = 1'b0;
    w_req       = 1'b0;
    w_fv        = 1'b0;
    w_t_clr     = 1'b0;
    w_t_load    = 1'b0;
    w_t_inc     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_t_clr = 1'b1;
        if (bus.start) begin
          w_state_nxt = ST_BOOT;
        end
      end
      ST_BOOT: begin
        w_en        = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_req = 1'b1;
        w_sel = SEL_NEXT;
        if (bus.mem_ready) begin
          if (w_redir != SEL_INIT) begin
            w_sel = w_redir;
            w_en  = 1'b1;
          end else if (!bus.stall) begin
            w_en = 1'b1;
            w_fv = 1'b1;
          end
        end else begin
          w_state_nxt = ST_MEM_WAIT;
          w_t_load    = 1'b1;
          w_pend_nxt  = w_redir;
        end
      end
      ST_MEM_WAIT: begin
        w_req = 1'b1;
        w_sel = SEL_NEXT;
        if (bus.mem_ready) begin
          if (w_eff != SEL_INIT) begin
            w_sel = w_eff;
            w_en  = 1'b1;
          end else if (!bus.stall) begin
            w_en = 1'b1;
            w_fv = 1'b1;
          end
          w_pend_nxt  = SEL_INIT;
          w_t_clr     = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (w_expired) begin
          w_state_nxt = ST_ERROR;
          w_err_set   = 1'b1;
        end else begin
          w_t_inc    = 1'b1;
          w_pend_nxt = w_eff;
        end
      end
      ST_ERROR: begin
        w_state_nxt = ST_ERROR;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Reset suppresses any load in its own cycle
  assign bus.sel = reset ? '0 : SEL_W'(w_sel);
  assign bus.enable      = !reset && w_en;
  assign bus.mem_req     = !reset && w_req;
  assign bus.fetch_valid = !reset && w_fv;
  assign bus.mem_error   = r_mem_error;
  assign bus.busy = !reset
                 && (r_state != ST_IDLE)
                 && (r_state != ST_ERROR);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed table, corner
// sequences and random traffic against a model.
module tb_fetch_sequencer;
  localparam int TO = 15;

  localparam int M_IDLE = 0;
  localparam int M_BOOT = 1;
  localparam int M_RUN  = 2;
  localparam int M_WAIT = 3;
  localparam int M_ERR  = 4;

  typedef struct {
    bit rst, start, stall, br, jmp, exc, mrdy;
  } in_t;

  typedef struct {
    logic [3:0] sel;
    bit selchk, en, req, fv, err, busy;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  fetch_sequencer_if #(.SEL_W(4)) bus ();

  fetch_sequencer #(
    .MEM_TIMEOUT(TO),
    .SEL_W      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int m_mode = M_IDLE;
  int m_cnt  = 0;
  int m_pend = 0;
  bit m_err  = 1'b0;

  function automatic in_t mi(
    bit rst, bit start, bit stall,
    bit br, bit jmp, bit exc, bit mrdy
  );
    in_t r;
    r.rst = rst; r.start = start; r.stall = stall;
    r.br = br; r.jmp = jmp; r.exc = exc;
    r.mrdy = mrdy;
    return r;
  endfunction

  function automatic exp_t me(
    int sel, bit selchk, bit en, bit req,
    bit fv, bit err, bit busy
  );
    exp_t r;
    r.sel = 4'(sel); r.selchk = selchk;
    r.en = en; r.req = req; r.fv = fv;
    r.err = err; r.busy = busy;
    return r;
  endfunction

  function automatic int redir_of(in_t i);
    if (i.exc) return 4;
    if (i.jmp) return 3;
    if (i.br)  return 2;
    return 0;
  endfunction

  function automatic exp_t model_eval(in_t i);
    exp_t e;
    int rd, eff;
    e = me(0, 1, 0, 0, 0, m_err, 0);
    if (i.rst) return e;
    rd = redir_of(i);
    if (m_mode == M_BOOT) begin
      e.en = 1; e.busy = 1;
    end else if (m_mode == M_RUN || m_mode == M_WAIT) begin
      e.busy = 1; e.req = 1;
      eff = rd;
      if (m_mode == M_WAIT && m_pend > rd) eff = m_pend;
      if (!i.mrdy) e.selchk = 0;
      else if (eff != 0) begin
        e.sel = 4'(eff); e.en = 1;
      end else if (i.stall) e.sel = 4'd1;
      else begin
        e.sel = 4'd1; e.en = 1; e.fv = 1;
      end
    end
    return e;
  endfunction

  task automatic model_update(in_t i);
    int rd;
    rd = redir_of(i);
    if (i.rst) begin
      m_mode = M_IDLE; m_cnt = 0;
      m_pend = 0; m_err = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (i.start) m_mode = M_BOOT;
      M_BOOT: m_mode = M_RUN;
      M_RUN: if (!i.mrdy) begin
        m_mode = M_WAIT; m_cnt = 1; m_pend = rd;
      end
      M_WAIT: begin
        if (i.mrdy) begin
          m_mode = M_RUN; m_pend = 0;
        end else if (m_cnt == TO) begin
          m_mode = M_ERR; m_err = 1;
        end else begin
          if (m_cnt < 255) m_cnt++;
          if (rd > m_pend) m_pend = rd;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check(string nm, exp_t e);
    bit bad;
    bad = (e.selchk && bus.sel !== e.sel)
       || bus.enable !== e.en
       || bus.mem_req !== e.req
       || bus.fetch_valid !== e.fv
       || bus.mem_error !== e.err
       || bus.busy !== e.busy;
    vectors++;
    if (bad) begin
      miscompares++;
      $display({"FAIL %s: got sel=%0d en=%0b req=%0b",
        " fv=%0b err=%0b busy=%0b; required sel=%0d",
        "(chk %0b) en=%0b req=%0b fv=%0b err=%0b",
        " busy=%0b"}, nm,
        bus.sel, bus.enable, bus.mem_req,
        bus.fetch_valid, bus.mem_error, bus.busy,
        e.sel, e.selchk, e.en, e.req, e.fv,
        e.err, e.busy);
    end
  endtask

  task automatic drive(in_t i);
    reset            = i.rst;
    bus.start        = i.start;
    bus.stall        = i.stall;
    bus.branch_taken = i.br;
    bus.jump         = i.jmp;
    bus.exception    = i.exc;
    bus.mem_ready    = i.mrdy;
  endtask

  task automatic step(
    string nm, in_t i, bit use_e, exp_t e
  );
    @(negedge clk);
    drive(i);
    #1;
    check({nm, "_model"}, model_eval(i));
    if (use_e) check(nm, e);
    @(posedge clk);
    model_update(i);
  endtask

  vec_t tbl[$];
  exp_t nx;
  exp_t wt;

  initial begin
    drive(mi(1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);

    nx = me(1, 1, 1, 1, 1, 0, 1);
    wt = me(0, 0, 0, 1, 0, 0, 1);
    // reset and boot
    tbl.push_back('{mi(1,0,0,0,0,0,1), me(0,1,0,0,0,0,0)});
    tbl.push_back('{mi(1,1,0,0,0,0,1), me(0,1,0,0,0,0,0)});
    tbl.push_back('{mi(0,0,0,1,1,1,1), me(0,1,0,0,0,0,0)});
    tbl.push_back('{mi(0,1,0,0,0,0,1), me(0,1,0,0,0,0,0)});
    tbl.push_back('{mi(0,0,0,0,0,0,1), me(0,1,1,0,0,0,1)});
    tbl.push_back('{mi(0,0,0,0,0,0,1), nx});
    tbl.push_back('{mi(0,0,0,0,0,0,1), nx});
    // three stall cycles then resume
    tbl.push_back('{mi(0,0,1,0,0,0,1), me(1,1,0,1,0,0,1)});
    tbl.push_back('{mi(0,0,1,0,0,0,1), me(1,1,0,1,0,0,1)});
    tbl.push_back('{mi(0,0,1,0,0,0,1), me(1,1,0,1,0,0,1)});
    tbl.push_back('{mi(0,0,0,0,0,0,1), nx});
    // all redirects plus stall
    tbl.push_back('{mi(0,0,1,1,1,1,1), me(4,1,1,1,0,0,1)});
    tbl.push_back('{mi(0,0,0,0,0,0,1), nx});
    tbl.push_back('{mi(0,1,0,0,0,0,1), nx});
    tbl.push_back('{mi(0,0,0,1,0,0,1), me(2,1,1,1,0,0,1)});
    tbl.push_back('{mi(0,0,0,1,1,0,1), me(3,1,1,1,0,0,1)});
    // wait with jump in cycle 2
    tbl.push_back('{mi(0,0,0,0,0,0,0), wt});
    tbl.push_back('{mi(0,0,0,0,1,0,0), wt});
    tbl.push_back('{mi(0,0,0,0,0,0,0), wt});
    tbl.push_back('{mi(0,0,0,0,0,0,0), wt});
    tbl.push_back('{mi(0,0,0,0,0,0,1), me(3,1,1,1,0,0,1)});
    tbl.push_back('{mi(0,0,0,0,0,0,1), nx});
    // stronger pending is kept over weaker
    tbl.push_back('{mi(0,0,0,0,0,1,0), wt});
    tbl.push_back('{mi(0,0,0,1,0,0,0), wt});
    tbl.push_back('{mi(0,0,0,0,0,0,1), me(4,1,1,1,0,0,1)});
    tbl.push_back('{mi(0,0,0,0,0,0,1), nx});
    // wait ends into a stall
    tbl.push_back('{mi(0,0,0,0,0,0,0), wt});
    tbl.push_back('{mi(0,0,1,0,0,0,1), me(1,1,0,1,0,0,1)});
    tbl.push_back('{mi(0,0,0,0,0,0,1), nx});

    foreach (tbl[k]) begin
      step($sformatf("tbl%0d", k), tbl[k].i, 1, tbl[k].e);
    end

    // memory timeout: 1 RUN miss + TO wait cycles
    for (int k = 1; k <= TO + 1; k++) begin
      step($sformatf("to_wait%0d", k),
           mi(0,0,0,0,0,0,0), 1, wt);
    end
    step("to_err", mi(0,1,0,0,0,0,1), 1,
         me(0,1,0,0,0,1,0));
    step("to_stick", mi(0,0,0,1,1,1,1), 1,
         me(0,1,0,0,0,1,0));
    step("to_rst", mi(1,0,0,0,0,0,1), 1,
         me(0,1,0,0,0,1,0));
    step("to_clr", mi(0,0,0,0,0,0,1), 1,
         me(0,1,0,0,0,0,0));

    // reset in wait with pending branch
    step("rw_s", mi(0,1,0,0,0,0,1), 1,
         me(0,1,0,0,0,0,0));
    step("rw_b", mi(0,0,0,0,0,0,1), 1,
         me(0,1,1,0,0,0,1));
    step("rw_m", mi(0,0,0,1,0,0,0), 1, wt);
    step("rw_w", mi(0,0,0,0,0,0,0), 1, wt);
    step("rw_r", mi(1,0,0,0,0,0,1), 1,
         me(0,1,0,0,0,0,0));
    step("rw_i", mi(0,0,0,0,0,0,1), 1,
         me(0,1,0,0,0,0,0));
    step("rw_s2", mi(0,1,0,0,0,0,1), 1,
         me(0,1,0,0,0,0,0));
    step("rw_b2", mi(0,0,0,0,0,0,1), 1,
         me(0,1,1,0,0,0,1));
    step("rw_n", mi(0,0,0,0,0,0,1), 1, nx);

    // random traffic with periodic long waits
    for (int k = 0; k < 3000; k++) begin
      in_t r;
      bit burst;
      burst = (k % 600) >= 560;
      r.rst   = ($urandom_range(99) < 2);
      r.start = ($urandom_range(99) < 15);
      r.stall = ($urandom_range(99) < 25);
      r.br    = ($urandom_range(99) < 10);
      r.jmp   = ($urandom_range(99) < 8);
      r.exc   = ($urandom_range(99) < 6);
      r.mrdy  = !burst && ($urandom_range(99) < 70);
      if (burst) r.rst = 1'b0;
      step($sformatf("rnd%0d", k), r, 0, nx);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
